sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_blitter_if.sv | 32 +++
 rtl/sprite_blitter.sv | 159 +++++++++++++++
 tb/tb_sprite_blitter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// Sprite blitter bus bundle: draw request/status, sprite ROM read port and
// frame-buffer write port. The slave modport is the blitter's view.
interface sprite_blitter_if #(
    parameter int ADDR_BITS = 9,
    parameter int FB_XW     = 10,
    parameter int FB_YW     = 9
);
    logic                 start;
    logic [FB_XW-1:0]     x0;
    logic [FB_YW-1:0]     y0;
    logic                 busy;
    logic                 done;
    logic [ADDR_BITS-1:0] rom_addr;
    logic [23:0]          color_in;
    logic                 fb_we;
    logic [FB_XW-1:0]     fb_x;
    logic [FB_YW-1:0]     fb_y;
    logic [23:0]          fb_data;
    logic                 fb_ready;

    // Host side: requests draws, supplies ROM data and frame-buffer readiness.
    modport master (
        output start, x0, y0, color_in, fb_ready,
        input  busy, done, rom_addr, fb_we, fb_x, fb_y, fb_data
    );

    // Blitter side.
    modport slave (
        input  start, x0, y0, color_in, fb_ready,
        output busy, done, rom_addr, fb_we, fb_x, fb_y, fb_data
    );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies an SPR_W x SPR_H sprite from a registered ROM into
// the frame buffer at (x0, y0), skipping pixels equal to the colour key.
// One pixel per cycle; a frame-buffer stall freezes the pipeline and
// re-presents the stalled pixel's ROM address so its colour stays valid.
module sprite_blitter #(
    parameter int          SPR_W     = 20,
    parameter int          SPR_H     = 20,
    parameter int          ADDR_BITS = 9,
    parameter int          FB_XW     = 10,
    parameter int          FB_YW     = 9,
    parameter logic [23:0] TRANSP    = 24'hFF00FF
) (
    input  logic           Clk,
    input  logic           Reset_n,
    sprite_blitter_if.slave bus
);

    localparam int N_PIX = SPR_W * SPR_H;
    localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N_PIX - 1);
    localparam logic [COL_W-1:0]     LAST_COL  = COL_W'(SPR_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic [FB_XW-1:0]     x0_r;
    logic [FB_YW-1:0]     y0_r;
    logic [ADDR_BITS-1:0] addr_r;
    logic [COL_W-1:0]     col_r;
    logic [ROW_W-1:0]     row_r;

    // Pending pixel: the address issued last cycle whose colour is on color_in now.
    logic                 pend_v_r;
    logic [ADDR_BITS-1:0] pend_addr_r;
    logic [FB_XW-1:0]     pend_x_r;
    logic [FB_YW-1:0]     pend_y_r;

    logic                 transp_s;
    logic                 stall_s;
    logic                 retire_s;
    logic                 issue_s;
    logic                 last_issue_s;
    logic                 accept_s;

    assign transp_s     = (bus.color_in == TRANSP);
    // Only an opaque pixel can be held up by the frame buffer.
    assign stall_s      = pend_v_r && !transp_s && !bus.fb_ready;
    assign retire_s     = pend_v_r && !stall_s;
    assign issue_s      = (state_r == ST_FETCH) && !stall_s;
    assign last_issue_s = issue_s && (addr_r == LAST_ADDR);
    assign accept_s     = (state_r == ST_IDLE) && bus.start;

    // Next-state selection for the draw sequencer.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (last_issue_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // The last pixel is the only one left; leave as soon as it retires.
                if (!stall_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, origin latch and raster address/column/row counters.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
            x0_r    <= {FB_XW{1'b0}};
            y0_r    <= {FB_YW{1'b0}};
            addr_r  <= {ADDR_BITS{1'b0}};
            col_r   <= {COL_W{1'b0}};
            row_r   <= {ROW_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                x0_r   <= bus.x0;
                y0_r   <= bus.y0;
                addr_r <= {ADDR_BITS{1'b0}};
                col_r  <= {COL_W{1'b0}};
                row_r  <= {ROW_W{1'b0}};
            end else if (issue_s) begin
                if (last_issue_s) begin
                    // Park at zero so the idle ROM address reads as 0.
                    addr_r <= {ADDR_BITS{1'b0}};
                    col_r  <= {COL_W{1'b0}};
                    row_r  <= {ROW_W{1'b0}};
                end else if (col_r == LAST_COL) begin
                    addr_r <= addr_r + ADDR_BITS'(1);
                    col_r  <= {COL_W{1'b0}};
                    row_r  <= row_r + ROW_W'(1);
                end else begin
                    addr_r <= addr_r + ADDR_BITS'(1);
                    col_r  <= col_r + COL_W'(1);
                end
            end
        end
    end

    // Pending-pixel register: loaded on every issue, cleared when it retires.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pend_v_r    <= 1'b0;
            pend_addr_r <= {ADDR_BITS{1'b0}};
            pend_x_r    <= {FB_XW{1'b0}};
            pend_y_r    <= {FB_YW{1'b0}};
        end else if (accept_s) begin
            pend_v_r    <= 1'b0;
        end else if (issue_s) begin
            pend_v_r    <= 1'b1;
            pend_addr_r <= addr_r;
            // Destination wraps naturally at the frame-buffer coordinate width.
            pend_x_r    <= x0_r + FB_XW'(col_r);
            pend_y_r    <= y0_r + FB_YW'(row_r);
        end else if (retire_s) begin
            pend_v_r    <= 1'b0;
        end
    end

    assign bus.busy     = (state_r == ST_FETCH) || (state_r == ST_DRAIN);
    assign bus.done     = (state_r == ST_DONE);
    // While stalled, re-present the pending address so the ROM keeps its colour valid.
    assign bus.rom_addr = stall_s ? pend_addr_r :
                          ((state_r == ST_FETCH) ? addr_r : {ADDR_BITS{1'b0}});
    assign bus.fb_we    = pend_v_r && !transp_s;
    assign bus.fb_x     = pend_x_r;
    assign bus.fb_y     = pend_y_r;
    assign bus.fb_data  = bus.color_in;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a reference model lists the expected
// frame-buffer writes per draw; a negedge monitor pops and compares them.
module tb_sprite_blitter;

    localparam int          SPR_W  = 20;
    localparam int          SPR_H  = 20;
    localparam int          AB     = 9;
    localparam int          XW     = 10;
    localparam int          YW     = 9;
    localparam logic [23:0] TRANSP = 24'hFF00FF;
    localparam int          N      = SPR_W * SPR_H;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] d;
        int          a;
    } exp_t;

    logic Clk;
    logic Reset_n;
    sprite_blitter_if #(.ADDR_BITS(AB), .FB_XW(XW), .FB_YW(YW)) bus ();

    sprite_blitter #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_BITS(AB),
        .FB_XW(XW), .FB_YW(YW), .TRANSP(TRANSP)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    logic [23:0] rom [0:(1<<AB)-1];
    exp_t        sb[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          s_cyc, done_cyc, stall_cnt, wr_cnt, first_wr, last_wr;
    bit          done_seen;
    int          rdy_mode = 0;
    bit          prev_stall = 0;
    int          px, py;
    logic [23:0] pd;
    exp_t        e;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Registered sprite ROM model.
    always @(posedge Clk) bus.color_in <= rom[bus.rom_addr];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: every non-key ROM word of the sprite, raster order.
    task automatic push_model(input int x, input int y);
        for (int a = 0; a < N; a++) begin
            if (rom[a] != TRANSP)
                sb.push_back('{x: (x + a % SPR_W) % (1 << XW),
                               y: (y + a / SPR_W) % (1 << YW),
                               d: rom[a], a: a});
        end
    endtask

    task automatic clear_counts();
        stall_cnt = 0;
        done_seen = 0;
        wr_cnt    = 0;
        first_wr  = -1;
        last_wr   = -1;
    endtask

    task automatic start_draw(input int x, input int y, input bit hold);
        push_model(x, y);
        @(posedge Clk); #1;
        bus.x0    = XW'(x);
        bus.y0    = YW'(y);
        bus.start = 1'b1;
        s_cyc     = cyc;
        clear_counts();
        @(posedge Clk); #1;
        if (!hold) bus.start = 1'b0;
        chk("fetch_busy", bus.busy, 1);
        chk("fetch_addr0", bus.rom_addr, 0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_seen && n < 4000) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!done_seen) chk({tag, "_timeout"}, 0, 1);
        else chk({tag, "_done_cycle"}, done_cyc - s_cyc, N + 2 + stall_cnt);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_idle_addr"}, bus.rom_addr, 0);
        chk({tag, "_idle_busy"}, bus.busy, 0);
        sb.delete();
    endtask

    // Frame-buffer readiness: always ready, random, or a 3-cycle stall on pixel 7.
    initial begin
        bus.fb_ready = 1'b1;
        forever begin
            @(posedge Clk); #1;
            case (rdy_mode)
                0: bus.fb_ready = 1'b1;
                1: bus.fb_ready = ($urandom_range(0, 9) < 7);
                2: bus.fb_ready = !(cyc >= s_cyc + 9 && cyc <= s_cyc + 11);
                default: bus.fb_ready = 1'b1;
            endcase
        end
    end

    // Monitor: consume accepted writes, check stalls hold, note done.
    always @(negedge Clk) begin
        if (!Reset_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_we", bus.fb_we, 1);
                chk("hold_x", bus.fb_x, px);
                chk("hold_y", bus.fb_y, py);
                chk("hold_data", bus.fb_data, pd);
            end
            if (bus.fb_we === 1'b1) begin
                chk("we_while_busy", bus.busy, 1);
                if (bus.fb_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_x", bus.fb_x, e.x);
                        chk("wr_y", bus.fb_y, e.y);
                        chk("wr_data", bus.fb_data, e.d);
                    end
                    wr_cnt++;
                    if (first_wr < 0) first_wr = cyc;
                    last_wr = cyc;
                end else begin
                    stall_cnt++;
                    if (sb.size() > 0) chk("stall_rom_addr", bus.rom_addr, sb[0].a);
                end
            end
            prev_stall = (bus.fb_we === 1'b1) && (bus.fb_ready !== 1'b1);
            px = bus.fb_x;
            py = bus.fb_y;
            pd = bus.fb_data;
            if (bus.done === 1'b1) begin
                chk("done_not_busy", bus.busy, 0);
                chk("done_no_we", bus.fb_we, 0);
                done_seen = 1;
                done_cyc  = cyc;
            end
        end
    end

    initial begin
        int rx, ry;
        Reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.x0    = '0;
        bus.y0    = '0;
        for (int a = 0; a < (1 << AB); a++) rom[a] = (a < N) ? 24'(a + 1) : 24'h0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_we", bus.fb_we, 0);
        chk("rst_addr", bus.rom_addr, 0);
        Reset_n = 1'b1;

        // Plain draw: 400 writes, first at +2, last at +N+1.
        rdy_mode = 0;
        start_draw(100, 50, 0);
        wait_done("basic");
        chk("basic_writes", wr_cnt, N);
        chk("basic_first_wr", first_wr - s_cyc, 2);
        chk("basic_last_wr", last_wr - s_cyc, N + 1);

        // Colour-keyed pixel 5 is skipped without costing time.
        rom[5] = TRANSP;
        start_draw(100, 50, 0);
        wait_done("transp");
        chk("transp_writes", wr_cnt, N - 1);
        chk("transp_done", done_cyc - s_cyc, N + 2);
        rom[5] = 24'(6);

        // Three-cycle stall on pixel 7.
        rdy_mode = 2;
        start_draw(100, 50, 0);
        wait_done("stall");
        chk("stall_cycles", stall_cnt, 3);
        chk("stall_done", done_cyc - s_cyc, N + 5);
        chk("stall_writes", wr_cnt, N);

        // Coordinate wrap in both axes.
        rdy_mode = 0;
        start_draw(1020, 500, 0);
        wait_done("wrap");

        // Random sprites with keyed pixels and random back-pressure.
        rdy_mode = 1;
        for (int t = 0; t < 3; t++) begin
            for (int a = 0; a < N; a++)
                rom[a] = ($urandom_range(0, 3) == 0) ? TRANSP : 24'($urandom);
            rx = $urandom_range(0, (1 << XW) - 1);
            ry = $urandom_range(0, (1 << YW) - 1);
            start_draw(rx, ry, 0);
            wait_done("random");
        end

        // Reset in the middle of a draw, with start asserted during reset.
        rdy_mode = 0;
        for (int a = 0; a < N; a++) rom[a] = 24'(a + 1);
        start_draw(10, 10, 0);
        while (cyc < s_cyc + 200) begin
            @(posedge Clk); #1;
        end
        Reset_n   = 1'b0;
        bus.start = 1'b1;
        sb.delete();
        @(posedge Clk); #1;
        Reset_n   = 1'b1;
        bus.start = 1'b0;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_we", bus.fb_we, 0);
        chk("midrst_addr", bus.rom_addr, 0);
        repeat (10) @(posedge Clk);
        #1;
        chk("midrst_stay_idle", bus.busy, 0);
        chk("midrst_no_done", done_seen, 0);
        start_draw(7, 9, 0);
        wait_done("after_rst");
        chk("after_rst_writes", wr_cnt, N);

        // start held high: one draw, then a new one accepted right after DONE.
        start_draw(30, 40, 1);
        wait_done("hold1");
        chk("hold_idle_gap", bus.busy, 0);
        push_model(30, 40);
        s_cyc = cyc;
        clear_counts();
        @(posedge Clk); #1;
        bus.start = 1'b0;
        chk("hold_restart_busy", bus.busy, 1);
        chk("hold_restart_addr", bus.rom_addr, 0);
        wait_done("hold2");
        chk("hold2_writes", wr_cnt, N);

        repeat (3) @(posedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
